// File: rtl/accum_if.sv
// Stream bundle for accum_unit: sample input stream plus block-result output stream.
// master = producer/consumer side (testbench or upstream logic), slave = accumulator.
interface accum_if #(parameter int N = 4);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] sum;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, sum, ovf, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, sum, ovf, out_valid
  );
endinterface

// File: rtl/accum_unit.sv
// Block accumulator: sums COUNT N-bit samples with carry tracking, presents total + sticky ovf.
// Optional macro ACCUM_SAT_EN: saturate the running sum to all ones on any carry-out.
module accum_unit #(
  parameter int N     = 4,
  parameter int COUNT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  accum_if.slave bus
);

  generate
    if (COUNT < 2 || COUNT > 256) begin : g_bad_count
      $error("accum_unit: COUNT must be in 2..256");
    end
  endgenerate

  localparam int CW = $clog2(COUNT);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t        state;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          ovf_r;
  logic          out_valid_r;
  logic          in_ready_r;

  logic [N:0]    add_full;
  logic [N-1:0]  acc_nxt;
  logic          accept;
  logic          take;
  logic          last;

  assign add_full = {1'b0, acc} + {1'b0, bus.in_data};

`ifdef ACCUM_SAT_EN
  // once saturated, acc is all ones, so any further nonzero add carries again
  assign acc_nxt = add_full[N] ? {N{1'b1}} : add_full[N-1:0];
`else
  assign acc_nxt = add_full[N-1:0];
`endif

  assign accept = bus.in_valid && in_ready_r;
  assign take   = out_valid_r && bus.out_ready;
  assign last   = (cnt == CW'(COUNT - 1));

  // in_ready is held as a register mirroring state==ACC, so it never sees out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (clr) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc   <= acc_nxt;
            ovf_r <= ovf_r | add_full[N];
            if (last) begin
              cnt         <= '0;
              state       <= HOLD;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (take) begin
            acc         <= '0;
            ovf_r       <= 1'b0;
            state       <= ACC;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= ACC;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sum       = acc;
  assign bus.ovf       = ovf_r;
  assign bus.out_valid = out_valid_r;
  assign bus.in_ready  = in_ready_r;

endmodule

// File: doc/accum_unit.md
Name: accum_unit

Overview:
- Sequential accumulator that sits directly downstream of the N-bit ripple adder.
- It sums a block of COUNT unsigned N-bit samples arriving over a valid/ready stream, using adder-style N-bit wrap plus carry.
- It presents the block total and a sticky overflow flag on a valid/ready output.
- It is used wherever the arithmetic datapath needs block sums, e.g. averaging or checksums.

Parameters:
- N, 4, sample and sum width in bits.
- COUNT, 4, samples per block. Legal range is 2..256; a value outside this range is a compile-time error.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous clear of the current block.
- in_data  input  N  sample.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample.
- sum  output  N  block total; meaningful only while out_valid=1.
- ovf  output  1  sticky: at least one add in this block produced carry-out.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset is asynchronous and active-high, named rst.
- rst=1 forces, immediately and without waiting for clk:
  - state=ACC, acc=0, cnt=0, ovf=0, sum=0, out_valid=0, in_ready=1.
  - This applies even mid-block or mid-HOLD; any partial block is discarded.
- States: ACC (collecting samples), HOLD (presenting result).
- in_ready = (state==ACC). It is a decode of state and has no combinational path from out_ready.
- Accept: in_valid && in_ready at a rising edge. On accept:
  - {c, acc} <= acc + in_data, computed at N+1 bits.
  - ovf <= ovf | c.
  - cnt <= cnt+1.
  - in_valid without in_ready is ignored, and cnt does not advance.
- cnt width is clog2(COUNT). When cnt==COUNT-1 on an accept, state -> HOLD and cnt -> 0.
- Latency: out_valid=1 on the edge after the COUNT-th accept. sum equals acc including that sample.
- In HOLD, sum and ovf are held stable until the handshake.
- Output handshake: out_valid && out_ready at an edge gives:
  - out_valid=0, acc=0, ovf=0, state -> ACC.
  - in_ready rises that same edge; there is no same-cycle bypass, so the next sample is accepted the cycle after.
- out_ready while out_valid=0 has no effect.
- clr=1 at an edge gives acc=0, cnt=0, ovf=0, out_valid=0, state=ACC.
  - clr has priority over the input and output handshakes in that cycle; a sample offered in that cycle is dropped.
- Wrap: without the optional feature, sum is the modulo 2^N total, and ovf flags any intermediate carry.
- In-range samples of value 0 are counted normally.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined: any add producing carry sets acc to all ones (2^N-1). Further adds keep it all ones. ovf is still set.
- Undefined: modulo wrap as above. No saturation logic is synthesized.

Test Plan:
- N=4, COUNT=4; samples 1,1,1,1 back-to-back, out_ready=1 -> out_valid high the cycle after the 4th accept, sum=4, ovf=0; in_ready high again the following cycle.
- Samples 15,1,0,0 -> without ACCUM_SAT_EN: sum=0, ovf=1. With ACCUM_SAT_EN: sum=15, ovf=1. The next block 2,2,2,2 gives sum=8, ovf=0 (flag cleared).
- Samples 3,3,3,3 with out_ready=0 for 5 cycles and in_valid=1 throughout -> out_valid, sum=12 stable, in_ready=0, no extra samples counted. Raising out_ready gives one handshake, and the next block then starts from 0.
- in_valid toggling 1,0,0,1,1,0,1 with data 5,x,x,2,1,x,4 -> only handshakes count; sum=12 after the 4th accept.
- Accept 7,7, pulse clr with in_valid=1 data=9 -> cnt=0, 9 dropped; then 1,2,3,4 gives sum=10, ovf=0.
- Accept 2 samples, assert rst asynchronously between edges -> sum=0, out_valid=0, ovf=0, in_ready=1 before the next edge; after release, 4,4,4,4 gives sum=0 (wrap), ovf=1.
